// File: rtl/uart_trx_param.sv
// uart_trx_param: parametrised full-duplex UART, LSB first, mid-bit sampled receiver.
// Define UART_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_trx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] txin,
    output logic              tx,
    output logic              txbusy,
    output logic              txdone,
    input  logic              rx,
    output logic [DATA_W-1:0] rxout,
    output logic              rxdone,
    output logic              rxerr,
    output logic              parerr
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int DCNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- TX
    state_t              tx_state, tx_next;
    logic [CNT_W-1:0]    tx_cnt;
    logic [DCNT_W-1:0]   tx_dcnt;
    logic                tx_scnt;
    logic [DATA_W-1:0]   tx_shift;
    logic                tx_bit_end;
    logic                tx_d, tx_done_d, tx_busy_d;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (start) tx_next = S_START;
            S_START: if (tx_bit_end) tx_next = S_DATA;
            S_DATA:
                if (tx_bit_end && tx_dcnt == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    tx_next = S_PARITY;
`else
                    tx_next = S_STOP;
`endif
                end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
`endif
            S_STOP:  if (tx_bit_end && tx_scnt == STOP_LAST) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic tx_par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_dcnt  <= '0;
            tx_scnt  <= 1'b0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_state == S_IDLE) begin
            tx_cnt  <= '0;
            tx_dcnt <= '0;
            tx_scnt <= 1'b0;
            if (start) begin
                tx_shift <= txin;
`ifdef UART_PARITY_EN
                tx_par   <= ^txin ^ 1'(PARITY_ODD);
`endif
            end
        end else if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == S_DATA) begin
                tx_shift <= tx_shift >> 1;
                tx_dcnt  <= tx_dcnt + 1'b1;
            end
            if (tx_state == S_STOP) tx_scnt <= tx_scnt + 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (tx_state)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = tx_par;
`endif
            default:  tx_d = 1'b1;
        endcase
        tx_done_d = (tx_state == S_STOP) && tx_bit_end && (tx_scnt == STOP_LAST);
        tx_busy_d = (tx_state != S_IDLE) && !tx_done_d;
    end

    // Registered pins: the line lags the FSM by one cycle, so tx falls the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx     <= 1'b1;
            txbusy <= 1'b0;
            txdone <= 1'b0;
        end else begin
            tx     <= tx_d;
            txbusy <= tx_busy_d;
            txdone <= tx_done_d;
        end
    end

    // ---------------------------------------------------------------- RX
    state_t              rx_state, rx_next;
    logic                rx_s1, rx_s2, rx_prev;
    logic                rx_fall;
    logic [CNT_W-1:0]    rx_cnt;
    logic [DCNT_W-1:0]   rx_dcnt;
    logic [DATA_W-1:0]   rx_shift;
    logic                rx_half_end, rx_bit_end;
    logic                rx_done_d;

    // Synchroniser resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall     = rx_prev & ~rx_s2;
    assign rx_half_end = (rx_cnt == HALF_LAST);
    assign rx_bit_end  = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_half_end) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_bit_end && rx_dcnt == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    rx_next = S_PARITY;
`else
                    rx_next = S_STOP;
`endif
                end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_bit_end) rx_next = S_STOP;
`endif
            S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic rx_par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_dcnt  <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else if (rx_state == S_IDLE) begin
            rx_cnt  <= '0;
            rx_dcnt <= '0;
        end else if (rx_state == S_START) begin
            rx_cnt <= rx_half_end ? '0 : rx_cnt + 1'b1;
        end else if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_state == S_DATA) begin
                rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                rx_dcnt  <= rx_dcnt + 1'b1;
            end
`ifdef UART_PARITY_EN
            if (rx_state == S_PARITY) rx_par <= rx_s2;
`endif
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    always_comb begin
        rx_done_d = (rx_state == S_STOP) && rx_bit_end;
    end

    // Only the first stop bit is checked; errors are flagged but data is always delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxdone <= 1'b0;
            rxout  <= '0;
            rxerr  <= 1'b0;
        end else begin
            rxdone <= rx_done_d;
            if (rx_done_d) begin
                rxout <= rx_shift;
                rxerr <= ~rx_s2;
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            parerr <= 1'b0;
        else if (rx_done_d) parerr <= (^rx_shift ^ 1'(PARITY_ODD)) != rx_par;
    end
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign parerr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_trx_param.sv
// Directed self-checking bench for uart_trx_param at default parameters.
// Parity cases are included when UART_PARITY_EN is defined for the build.
module tb_uart_trx_param;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = 1 + DATA_W + P + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] txin = '0;
    logic              tx, txbusy, txdone;
    logic              rx, rxdone, rxerr, parerr;
    logic [DATA_W-1:0] rxout;
    logic              loopback = 1'b0;
    logic              rx_drv = 1'b1;
`ifdef UART_PARITY_EN
    logic              par_flip = 1'b0;
`endif

    assign rx = loopback ? tx : rx_drv;

    uart_trx_param dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .txin   (txin),
        .tx     (tx),
        .txbusy (txbusy),
        .txdone (txdone),
        .rx     (rx),
        .rxout  (rxout),
        .rxdone (rxdone),
        .rxerr  (rxerr),
        .parerr (parerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                n_cmp = 0;
    int                n_err = 0;
    int                txd_q[$];
    int                rxd_q[$];
    logic [DATA_W-1:0] rxdata_q[$];
    logic              rxerr_q[$];
    logic              parerr_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (txdone) txd_q.push_back(cyc);
            if (rxdone) begin
                rxd_q.push_back(cyc);
                rxdata_q.push_back(rxout);
                rxerr_q.push_back(rxerr);
                parerr_q.push_back(parerr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        txd_q.delete();
        rxd_q.delete();
        rxdata_q.delete();
        rxerr_q.delete();
        parerr_q.delete();
    endtask

    // Expected serial frame, bit 0 = start bit; bits beyond the frame stay 1.
    function automatic logic [15:0] make_frame(input logic [DATA_W-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
        f[1+DATA_W] = ^d;
`endif
        return f;
    endfunction

    // Pulse start, check the accept timing, and capture tx at each bit centre.
    task automatic tx_loop(input logic [DATA_W-1:0] d, output logic [15:0] frame, output int acc);
        int off;
        @(negedge clk);
        txin  = d;
        start = 1'b1;
        acc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        frame = '1;
        check("accept_tx_high", tx, 1);
        check("accept_not_busy", txbusy, 0);
        @(negedge clk);
        check("start_bit_low", tx, 0);
        check("busy_after_accept", txbusy, 1);
        for (int i = 0; i < F * CPB + 40; i++) begin
            off = cyc - acc;
            if (off >= CPB / 2 && (off - CPB / 2) % CPB == 0 && (off - CPB / 2) / CPB < F)
                frame[(off - CPB / 2) / CPB] = tx;
            @(negedge clk);
        end
    endtask

    // Bench-driven serial frame on rx with a chosen stop-bit level.
    task automatic drive_frame(input logic [DATA_W-1:0] d, input logic stop_v);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = ^d ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx_drv = stop_v;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        logic [15:0] frame;
        int          acc;
        int          guard;
        int          bad;
        int          dt;

        // Reset state and quiet idle line
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_txbusy", txbusy, 0);
        check("rst_txdone", txdone, 0);
        check("rst_rxdone", rxdone, 0);
        check("rst_rxerr", rxerr, 0);
        check("rst_parerr", parerr, 0);
        check("rst_rxout", rxout, 0);
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || txbusy !== 1'b0 || txdone !== 1'b0 || rxdone !== 1'b0 ||
                rxerr !== 1'b0 || parerr !== 1'b0 || rxout !== '0)
                bad++;
        end
        check("idle_quiet", bad, 0);

        // Loopback 0xA5
        loopback = 1'b1;
        clear_q();
        tx_loop(8'hA5, frame, acc);
        check("a5_frame", frame, make_frame(8'hA5));
        check("a5_txdone_cnt", txd_q.size(), 1);
        check("a5_txdone_lat", (txd_q.size() > 0) ? txd_q[0] - acc : -1, F * CPB);
        check("a5_rxdone_cnt", rxd_q.size(), 1);
        check("a5_rxout", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'hA5);
        check("a5_rxerr", (rxerr_q.size() > 0) ? rxerr_q[0] : 1'bx, 0);
        check("a5_parerr", (parerr_q.size() > 0) ? parerr_q[0] : 1'bx, 0);
        dt = (rxd_q.size() > 0 && txd_q.size() > 0) ? rxd_q[0] - txd_q[0] : 9999;
        check("a5_loop_window", (dt >= -(CPB / 2) && dt <= CPB / 2 + 3), 1);

        // Back-to-back 0x00 then 0xFF with start held high
        clear_q();
        @(negedge clk);
        txin  = 8'h00;
        start = 1'b1;
        acc   = cyc + 1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (txdone !== 1'b1 && guard < 400);
        check("b2b_first_lat", cyc - acc, F * CPB);
        txin = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (F * CPB + 40) @(negedge clk);
        check("b2b_txdone_cnt", txd_q.size(), 2);
        check("b2b_txdone_gap", (txd_q.size() > 1) ? txd_q[1] - txd_q[0] : -1, F * CPB + 1);
        check("b2b_rxdone_cnt", rxd_q.size(), 2);
        check("b2b_rx0", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'h00);
        check("b2b_rx1", (rxdata_q.size() > 1) ? rxdata_q[1] : 'x, 8'hFF);

        // Glitch rejection, then a valid frame
        loopback = 1'b0;
        rx_drv   = 1'b1;
        repeat (20) @(negedge clk);
        clear_q();
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rxdone", rxd_q.size(), 0);
        drive_frame(8'h3C, 1'b1);
        check("after_glitch_cnt", rxd_q.size(), 1);
        check("after_glitch_rxout", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'h3C);
        check("after_glitch_rxerr", (rxerr_q.size() > 0) ? rxerr_q[0] : 1'bx, 0);

        // Framing error: stop bit driven low
        clear_q();
        drive_frame(8'h55, 1'b0);
        check("frame_err_cnt", rxd_q.size(), 1);
        check("frame_err_rxout", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'h55);
        check("frame_err_rxerr", (rxerr_q.size() > 0) ? rxerr_q[0] : 1'bx, 1);

        // Reset mid-frame aborts with no completion pulses
        loopback = 1'b1;
        clear_q();
        @(negedge clk);
        txin  = 8'h81;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", txbusy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (250) @(negedge clk);
        check("midrst_no_txdone", txd_q.size(), 0);
        check("midrst_no_rxdone", rxd_q.size(), 0);

`ifdef UART_PARITY_EN
        // Even parity of 0x07 is 1; then a flipped parity bit is flagged
        clear_q();
        tx_loop(8'h07, frame, acc);
        check("par_bit_on_tx", frame[1+DATA_W], 1);
        check("par_loop_rxout", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'h07);
        check("par_loop_parerr", (parerr_q.size() > 0) ? parerr_q[0] : 1'bx, 0);
        loopback = 1'b0;
        clear_q();
        par_flip = 1'b1;
        drive_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        check("par_inj_cnt", rxd_q.size(), 1);
        check("par_inj_parerr", (parerr_q.size() > 0) ? parerr_q[0] : 1'bx, 1);
        check("par_inj_rxout", (rxdata_q.size() > 0) ? rxdata_q[0] : 'x, 8'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_trx_param.md
# uart_trx_param

Parametrised full-duplex UART transceiver; successor to the fixed 8-bit `uart_dut`, with the same `start`/`txin`/`tx`/`txdone` and `rx`/`rxout`/`rxdone` handshake. It adds the following:
- configurable data width, bit period and stop-bit count;
- mid-bit sampled receiver with input synchroniser;
- false-start rejection and framing-error reporting;
- optional parity.

It sits between the system clock domain and the serial pins and is driven directly by the existing interface-based bench.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit, even, ≥ 4.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Only meaningful when `UART_PARITY_EN` is defined.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: transmit request. Sampled only while TX is idle.
- `txin` input `DATA_W`: transmit data, captured on the accepted `start`.
- `tx` output 1: serial out, idle high.
- `txbusy` output 1: high from the cycle after accept until `txdone`.
- `txdone` output 1: one-cycle pulse at the end of the last stop bit.
- `rx` input 1: asynchronous serial in.
- `rxout` output `DATA_W`: received data, updated with `rxdone`, held until the next `rxdone`.
- `rxdone` output 1: one-cycle pulse per completed frame.
- `rxerr` output 1: framing error (stop bit sampled low), valid with `rxdone`.
- `parerr` output 1: parity mismatch, valid with `rxdone`. Tied 0 without `UART_PARITY_EN`.

## Operation
- Reset values: `tx`=1; `txbusy`, `txdone`, `rxdone`, `rxerr`, `parerr`=0; `rxout`=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts immediately; `tx` returns high, with no `txdone` or `rxdone`.
- Frame format:
  - 1 start bit (0);
  - `DATA_W` data bits, LSB first;
  - [parity bit];
  - `STOP_BITS` stop bits (1).
- Frame length F = 1 + `DATA_W` + P + `STOP_BITS` bits, where P is 1 with parity and 0 without.
- TX FSM (IDLE→START→DATA→PARITY→STOP→IDLE):
  - In IDLE, `start`=1 latches `txin` into a shift register.
  - Each state holds its bit for `CLKS_PER_BIT` cycles, counted by a bit-period counter.
  - A data counter runs 0..`DATA_W`-1.
  - PARITY is skipped when compiled out.
- TX handshake:
  - `start` while busy is ignored, with no queuing.
  - `start` held high in the `txdone` cycle is not accepted. It is accepted on the following cycle if still high, giving back-to-back frames with exactly one idle-high cycle between them.
- RX synchroniser and start detect:
  - `rx` passes through a 2-flop synchroniser.
  - In IDLE, a synchronised 1→0 transition enters START.
- RX START state:
  - After `CLKS_PER_BIT`/2 cycles the line is re-sampled.
  - If it is high, the start was false: return to IDLE with no pulse.
  - If it is low, continue to DATA.
- RX DATA/PARITY/STOP: each bit is sampled every `CLKS_PER_BIT` cycles at bit centre. With 2 stop bits, only the first is checked.
- RX completion:
  - On the stop sample, `rxout`, `rxerr` and `parerr` are loaded, and `rxdone` pulses in the same cycle.
  - The FSM returns to IDLE. It accepts a new falling edge the cycle after `rxdone`, so the second stop bit is not waited for.
- `rxerr`/`parerr` do not suppress `rxdone`. Data is always delivered.

## Timing
- TX:
  - `start` accepted at edge N.
  - `tx` goes 0 and `txbusy` goes 1 after edge N+1.
  - Bit k occupies edges N+1+k·`CLKS_PER_BIT` .. N+(k+1)·`CLKS_PER_BIT`.
  - `txdone` is high for the cycle after edge N+F·`CLKS_PER_BIT`, with `txbusy` dropping on that same edge.
- RX:
  - Latency from the `rx` falling edge to start detect is 2 cycles (synchroniser) plus 1 (edge detect).
  - Centre sample of bit k is `CLKS_PER_BIT`/2 + k·`CLKS_PER_BIT` cycles after detect.
  - `rxdone` is 1 cycle after the stop centre sample.
- Loopback, defaults, no parity: `rxdone` follows `txdone` by no more than `CLKS_PER_BIT`/2+3 cycles and precedes it by no more than `CLKS_PER_BIT`/2.

## Configuration
- Macro `UART_PARITY_EN`.
- Defined: TX inserts a parity bit after the data bits. The bit is the XOR of the data bits, XOR `PARITY_ODD`. RX checks it and drives `parerr`. F includes P=1.
- Undefined: there is no parity state in either FSM, P=0, and `parerr` is constant 0.

## Test plan
- Reset then idle, defaults: `tx`=1, all pulses 0, `rxout`=0 for 1000 cycles.
- Loopback (`rx`=`tx`), `txin`=0xA5, `start` pulse, no parity: `txdone` 160 cycles after accept, `rxdone` with `rxout`=0xA5, `rxerr`=0, `parerr`=0.
- Back-to-back: `start` held high across 0x00 then 0xFF: exactly two `txdone` pulses 161 cycles apart; RX delivers 0x00 then 0xFF.
- Glitch: `rx` low for 4 cycles, then high: no `rxdone`; a valid 0x3C frame sent afterwards is received correctly.
- Framing: frame 0x55 driven with stop bit 0: `rxdone`=1, `rxerr`=1, `rxout`=0x55.
- `UART_PARITY_EN`, `PARITY_ODD`=0:
  - loopback 0x07 shows a parity bit of 1 on `tx` and `parerr`=0;
  - a bench-injected flipped parity bit gives `parerr`=1.
